// File: rtl/imem_load_port_pkg.sv
// Shared types and constants for the instruction RAM and its byte-stream load port.
package imem_load_port_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'hE1A00000;

  localparam int unsigned LANE_BITS = 8;
  localparam int unsigned LANES     = 4;
  localparam logic [1:0]  LAST_LANE = 2'd3;

  // Bytes arrive lowest lane first, so the final byte lands in the top lane.
  function automatic logic [31:0] pack_word(input logic [23:0] low_lanes,
                                            input logic [7:0]  top_lane);
    return {top_lane, low_lanes};
  endfunction

endpackage

// File: rtl/imem_load_port_if.sv
// Valid/ready program-byte stream feeding the instruction RAM loader.
interface imem_load_port_if;

  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );

endinterface

// File: rtl/imem_load_port_word_ram.sv
// DEPTH x 32 instruction store: synchronous write, asynchronous read.
module imem_word_ram #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [31:0]              i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Contents are intentionally not reset; the word count gates every read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_load_port.sv
// Instruction RAM with a byte-stream program-load port; freezes the CPU while a
// program is streamed in and serves combinational fetch reads otherwise.
module imem_load_port
  import imem_load_port_pkg::*;
#(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load_start,
  imem_load_port_if.slave        ld_if,
  input  logic [31:0]            i_pc,
  output logic [31:0]            o_instruction,
  output logic                   o_cpu_freeze,
  output logic                   o_load_done,
  output logic                   o_load_error,
  output logic [$clog2(DEPTH):0] o_word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_e        r_state;
  logic [1:0]    r_byte_idx;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_word_count;
  logic [23:0]   r_shift;
  logic          r_ld_ready;
  logic          r_cpu_freeze;
  logic          r_load_done;
  logic          r_load_error;

  logic          w_take;
  logic          w_word_end;
  logic          w_finish_ok;
  logic          w_finish_bad;
  logic          w_overflow;
  logic [31:0]   w_wdata;
  logic [AW-1:0] w_widx;
  logic [29:0]   w_pc_word;
  logic          w_hit;
  logic [31:0]   w_rdata;

  assign w_take       = (r_state == ST_LOAD) && r_ld_ready && ld_if.ld_valid;
  assign w_word_end   = w_take && (r_byte_idx == LAST_LANE);
  assign w_finish_ok  = w_word_end && ld_if.ld_last;
  assign w_finish_bad = w_take && ld_if.ld_last && (r_byte_idx != LAST_LANE);
  assign w_overflow   = w_word_end && !ld_if.ld_last && (r_wr_ptr == LAST_PTR);
  assign w_wdata      = pack_word(r_shift, ld_if.ld_data);

  imem_word_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_word_end),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (w_widx),
    .o_rdata (w_rdata)
  );

  // Load FSM, byte packer, write pointer and all registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_byte_idx   <= 2'd0;
      r_wr_ptr     <= '0;
      r_word_count <= '0;
      r_shift      <= 24'd0;
      r_ld_ready   <= 1'b0;
      r_cpu_freeze <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_load_start) begin
            r_state      <= ST_LOAD;
            r_ld_ready   <= 1'b1;
            r_cpu_freeze <= 1'b1;
            r_wr_ptr     <= '0;
            r_byte_idx   <= 2'd0;
            r_word_count <= '0;
            r_load_error <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_take) begin
            // Shifting in from the top leaves byte k at bits [8k+7:8k] after three bytes.
            r_shift    <= {ld_if.ld_data, r_shift[23:8]};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_word_end) begin
              r_wr_ptr     <= r_wr_ptr + AW'(1);
              r_word_count <= {1'b0, r_wr_ptr} + CW'(1);
            end
            if (w_finish_ok) begin
              r_state      <= ST_IDLE;
              r_ld_ready   <= 1'b0;
              r_cpu_freeze <= 1'b0;
              r_load_done  <= 1'b1;
            end else if (w_finish_bad || w_overflow) begin
              r_state      <= ST_IDLE;
              r_ld_ready   <= 1'b0;
              r_cpu_freeze <= 1'b0;
              r_load_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_ld_ready   <= 1'b0;
          r_cpu_freeze <= 1'b0;
        end
      endcase
    end
  end

  assign w_widx    = i_pc[AW+1:2];
  assign w_pc_word = i_pc[31:2];
  assign w_hit     = (r_state == ST_IDLE) && (w_pc_word < {{(30-CW){1'b0}}, r_word_count});

  // Fetch lookup: only loaded words are visible, and nothing while loading.
  always_comb begin
    if (w_hit) begin
      o_instruction = w_rdata;
    end else begin
      o_instruction = NOP_WORD;
    end
  end

  assign ld_if.ld_ready = r_ld_ready;
  assign o_cpu_freeze   = r_cpu_freeze;
  assign o_load_done    = r_load_done;
  assign o_load_error   = r_load_error;
  assign o_word_count   = r_word_count;

endmodule

// File: tb/tb_imem_load_port.sv
// Bench for imem_load_port: two instances (DEPTH 64 and DEPTH 4) sharing one stimulus path.
module tb_imem_load_port;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        tb_sel;
  logic        tb_start;
  logic        tb_valid;
  logic        tb_last;
  logic [7:0]  tb_data;
  logic [31:0] tb_pc;

  always #5 clk = ~clk;

  imem_load_port_if ifa ();
  imem_load_port_if ifb ();

  assign ifa.ld_valid = tb_valid & ~tb_sel;
  assign ifa.ld_data  = tb_data;
  assign ifa.ld_last  = tb_last;
  assign ifb.ld_valid = tb_valid & tb_sel;
  assign ifb.ld_data  = tb_data;
  assign ifb.ld_last  = tb_last;

  logic [31:0] a_instr, b_instr;
  logic        a_freeze, b_freeze, a_done, b_done, a_err, b_err;
  logic [6:0]  a_count;
  logic [2:0]  b_count;

  imem_load_port #(.DEPTH(64)) dut_a (
    .clk(clk), .rst(rst), .i_load_start(tb_start & ~tb_sel), .ld_if(ifa.slave),
    .i_pc(tb_pc), .o_instruction(a_instr), .o_cpu_freeze(a_freeze),
    .o_load_done(a_done), .o_load_error(a_err), .o_word_count(a_count)
  );

  imem_load_port #(.DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .i_load_start(tb_start & tb_sel), .ld_if(ifb.slave),
    .i_pc(tb_pc), .o_instruction(b_instr), .o_cpu_freeze(b_freeze),
    .o_load_done(b_done), .o_load_error(b_err), .o_word_count(b_count)
  );

  logic [31:0] w_instr, w_count;
  logic        w_ready, w_freeze, w_done, w_err;
  assign w_instr  = tb_sel ? b_instr : a_instr;
  assign w_ready  = tb_sel ? ifb.ld_ready : ifa.ld_ready;
  assign w_freeze = tb_sel ? b_freeze : a_freeze;
  assign w_done   = tb_sel ? b_done : a_done;
  assign w_err    = tb_sel ? b_err : a_err;
  assign w_count  = tb_sel ? 32'(b_count) : 32'(a_count);

  int total = 0;
  int bad = 0;
  int done_total = 0;
  logic [7:0] pbytes [0:63];

  always @(negedge clk) begin
    if (w_done) done_total <= done_total + 1;
  end

  typedef struct {
    bit sel;
    int len;
    bit use_last;
    int gap_at;
    bit mid_start;
    int exp_count;
    bit exp_err;
    bit exp_done;
    int exp_acc;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int i);
    return {pbytes[4*i+3], pbytes[4*i+2], pbytes[4*i+1], pbytes[4*i]};
  endfunction

  // Outcome of streaming len bytes (ld_last on the final one if use_last).
  task automatic model_outcome(input int len, input bit use_last, input int depth,
                               output int count, output bit err, output bit done, output int acc);
    int cap;
    cap = 4 * depth;
    if (len > cap || (len == cap && !use_last)) begin
      count = depth; err = 1'b1; done = 1'b0; acc = cap;
    end else begin
      count = len / 4; err = (len % 4) != 0; done = (len % 4) == 0; acc = len;
    end
  endtask

  task automatic run_load(input int len, input bit use_last, input int gap_at, input bit mid_start,
                          input int gap_pct, output int acc, output int rej, output bit frz_ok);
    int i, gdone, guard;
    bit gap, rdy;
    acc = 0; rej = 0; frz_ok = 1'b1; i = 0; gdone = 0; guard = 0;
    @(negedge clk); tb_start = 1'b1;
    @(negedge clk); tb_start = 1'b0;
    while (i < len && guard < 4000) begin
      guard++;
      gap = 1'b0;
      if (i == gap_at && gdone < 3) begin
        gap = 1'b1;
        gdone++;
      end else if (int'($urandom_range(99)) < gap_pct) begin
        gap = 1'b1;
      end
      rdy = w_ready;
      if (w_freeze !== w_ready) frz_ok = 1'b0;
      tb_valid = !gap;
      tb_data  = pbytes[i];
      tb_last  = use_last && (i == len - 1);
      tb_start = mid_start && (i == 2) && !gap;
      @(negedge clk);
      if (!gap) begin
        if (rdy) acc++; else rej++;
        i++;
      end
    end
    tb_valid = 1'b0; tb_last = 1'b0; tb_start = 1'b0;
    if (guard >= 4000) begin
      total++; bad++;
      $display("FAIL load_timeout: got %0d bytes sent want %0d", i, len);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_after(input string nm, input int depth, input int ecount, input bit eerr,
                             input bit edone, input int dstart, input int acc, input int rej,
                             input int eacc, input int erej, input bit frz_ok);
    chk({nm, "_count"}, w_count, 32'(ecount));
    chk({nm, "_err"}, 32'(w_err), 32'(eerr));
    chk({nm, "_done_pulses"}, 32'(done_total - dstart), 32'(edone));
    chk({nm, "_freeze_after"}, 32'(w_freeze), 32'd0);
    chk({nm, "_ready_after"}, 32'(w_ready), 32'd0);
    chk({nm, "_accepted"}, 32'(acc), 32'(eacc));
    chk({nm, "_rejected"}, 32'(rej), 32'(erej));
    chk({nm, "_freeze_track"}, 32'(frz_ok), 32'd1);
    for (int i = 0; i < depth && i < ecount + 2; i++) begin
      tb_pc = 32'(i * 4) | 32'($urandom_range(3));
      #1;
      chk({nm, "_rd"}, w_instr, (i < ecount) ? model_word(i) : NOP);
    end
    tb_pc = 32'hFFFF_FFFC;
    #1;
    chk({nm, "_rd_top"}, w_instr, NOP);
    @(negedge clk);
  endtask

  initial begin
    int acc, rej, ecount, eacc, dstart;
    bit frz_ok, eerr, edone;

    rst = 1'b1; tb_sel = 1'b0; tb_start = 1'b0; tb_valid = 1'b0; tb_last = 1'b0;
    tb_data = 8'd0; tb_pc = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_instr", w_instr, NOP);
    chk("rst_count", w_count, 32'd0);
    chk("rst_freeze", 32'(w_freeze), 32'd0);
    chk("rst_ready", 32'(w_ready), 32'd0);
    chk("rst_done", 32'(w_done), 32'd0);
    chk("rst_err", 32'(w_err), 32'd0);
    chk("rst_count_b", 32'(b_count), 32'd0);

    vt[0] = '{1'b0, 4,  1'b1, -1, 1'b0, 1, 1'b0, 1'b1, 4};
    vt[1] = '{1'b0, 8,  1'b1,  4, 1'b0, 2, 1'b0, 1'b1, 8};
    vt[2] = '{1'b0, 6,  1'b1, -1, 1'b0, 1, 1'b1, 1'b0, 6};
    vt[3] = '{1'b1, 20, 1'b0, -1, 1'b0, 4, 1'b1, 1'b0, 16};
    vt[4] = '{1'b0, 1,  1'b1, -1, 1'b0, 0, 1'b1, 1'b0, 1};
    vt[5] = '{1'b1, 16, 1'b1, -1, 1'b0, 4, 1'b0, 1'b1, 16};
    vt[6] = '{1'b0, 12, 1'b1, -1, 1'b1, 3, 1'b0, 1'b1, 12};
    vt[7] = '{1'b1, 13, 1'b1,  2, 1'b0, 3, 1'b1, 1'b0, 13};

    for (int v = 0; v < 8; v++) begin
      for (int b = 0; b < 64; b++) pbytes[b] = 8'($urandom);
      if (v == 0) begin
        pbytes[0] = 8'h14; pbytes[1] = 8'h00; pbytes[2] = 8'hA0; pbytes[3] = 8'hE3;
      end
      tb_sel = vt[v].sel;
      dstart = done_total;
      run_load(vt[v].len, vt[v].use_last, vt[v].gap_at, vt[v].mid_start, 0, acc, rej, frz_ok);
      check_after($sformatf("vec%0d", v), vt[v].sel ? 4 : 64, vt[v].exp_count, vt[v].exp_err,
                  vt[v].exp_done, dstart, acc, rej, vt[v].exp_acc, vt[v].len - vt[v].exp_acc, frz_ok);
      if (v == 0) begin
        tb_pc = 32'd0; #1; chk("t2_word0", w_instr, 32'hE3A00014);
        tb_pc = 32'd4; #1; chk("t2_word1", w_instr, NOP);
        @(negedge clk);
      end
    end

    // Reset in the middle of a load on the DEPTH-64 instance.
    tb_sel = 1'b0;
    @(negedge clk); tb_start = 1'b1;
    @(negedge clk); tb_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tb_valid = 1'b1; tb_data = 8'(i + 1); tb_last = 1'b0;
      @(negedge clk);
    end
    tb_valid = 1'b0;
    chk("mid_ready_pre", 32'(w_ready), 32'd1);
    chk("mid_freeze_pre", 32'(w_freeze), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(w_ready), 32'd0);
    chk("mid_rst_freeze", 32'(w_freeze), 32'd0);
    chk("mid_rst_count", w_count, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tb_pc = 32'($urandom_range(255));
      #1;
      chk("mid_rst_rd", w_instr, NOP);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 64; b++) pbytes[b] = 8'($urandom);
    dstart = done_total;
    run_load(8, 1'b1, -1, 1'b0, 0, acc, rej, frz_ok);
    check_after("after_rst", 64, 2, 1'b0, 1'b1, dstart, acc, rej, 8, 0, frz_ok);

    // Randomized loads against the reference outcome model.
    for (int r = 0; r < 30; r++) begin
      int len, depth;
      tb_sel = 1'($urandom_range(1));
      depth = tb_sel ? 4 : 64;
      len = int'($urandom_range(tb_sel ? 22 : 40, 1));
      for (int b = 0; b < 64; b++) pbytes[b] = 8'($urandom);
      model_outcome(len, 1'b1, depth, ecount, eerr, edone, eacc);
      dstart = done_total;
      run_load(len, 1'b1, -1, 1'b0, 25, acc, rej, frz_ok);
      check_after($sformatf("rnd%0d", r), depth, ecount, eerr, edone, dstart, acc, rej,
                  eacc, len - eacc, frz_ok);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
